// File: rtl/lc3_mmio_pkg.sv
// Shared constants and types for the LC-3 memory-mapped I/O block.
// Register addresses, status bit positions and the interrupt request record.
package lc3_mmio_pkg;

   localparam logic [15:0] ADDR_KBSR = 16'hFE00;
   localparam logic [15:0] ADDR_KBDR = 16'hFE02;
   localparam logic [15:0] ADDR_DSR  = 16'hFE04;
   localparam logic [15:0] ADDR_DDR  = 16'hFE06;
   localparam logic [15:0] ADDR_MCR  = 16'hFFFE;

   localparam int BIT_READY = 15;
   localparam int BIT_IE    = 14;
   localparam int BIT_RUN   = 15;

   typedef struct packed {
      logic [2:0] pri;
      logic [7:0] vec;
   } irq_req_t;

endpackage

// File: rtl/lc3_sync_fifo.sv
// Single-clock FIFO; head is visible combinationally, push/pop take effect on the edge.
// Push is ignored when full and pop when empty, so callers may drive them freely.
module lc3_sync_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push,
   input  logic             pop,
   input  logic [WIDTH-1:0] din,
   output logic [WIDTH-1:0] dout,
   output logic             full,
   output logic             empty
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic [AW:0]      count;
   logic             do_push;
   logic             do_pop;

   assign full    = (count == FULL_CNT);
   assign empty   = (count == '0);
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;
   assign dout    = mem[rd_ptr];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + AW'(1);
         if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
         case ({do_push, do_pop})
            2'b10:   count <= count + (AW+1)'(1);
            2'b01:   count <= count - (AW+1)'(1);
            default: count <= count;
         endcase
      end
   end

   // Storage needs no reset: occupancy is tracked solely by count.
   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= din;
   end

endmodule

// File: rtl/lc3_mmio_ctrl.sv
// LC-3 MMIO block: keyboard FIFO, display holding register, MCR and interrupt arbiter.
// Reads are combinational; keyboard source stalls on kbd_ready, display holds until dsp_ready.
module lc3_mmio_ctrl
   import lc3_mmio_pkg::*;
#(
   parameter int         KBD_DEPTH = 4,
   parameter logic [2:0] KBD_PRI   = 3'd4,
   parameter logic [2:0] DSP_PRI   = 3'd4,
   parameter logic [7:0] KBD_VEC   = 8'h80,
   parameter logic [7:0] DSP_VEC   = 8'h81
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [15:0] addr,
   input  logic [15:0] io_wdata,
   input  logic        io_we,
   input  logic        io_re,
   output logic [15:0] io_rdata,
   input  logic        kbd_valid,
   input  logic [7:0]  kbd_data,
   output logic        kbd_ready,
   output logic        dsp_valid,
   output logic [7:0]  dsp_data,
   input  logic        dsp_ready,
   output logic        IRQ,
   output logic [2:0]  INTP,
   output logic [7:0]  INTV,
   output logic        mcr_run
);

   logic       fifo_full;
   logic       fifo_empty;
   logic [7:0] fifo_head;
   logic       kbd_pop;
   logic       kbsr_ie;
   logic       dsr_ie;
   logic       dsr_ready;
   logic       kbd_req;
   logic       dsp_req;
   irq_req_t   win;
   irq_req_t   cur;
   logic       unused_bits;

   assign unused_bits = &{1'b0, io_wdata[13:8]};

   assign kbd_ready = !fifo_full;
   assign kbd_pop   = io_re && (addr == ADDR_KBDR);

   lc3_sync_fifo #(.WIDTH(8), .DEPTH(KBD_DEPTH)) u_kbd_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (kbd_valid),
      .pop   (kbd_pop),
      .din   (kbd_data),
      .dout  (fifo_head),
      .full  (fifo_full),
      .empty (fifo_empty)
   );

   // A pending display character is exactly the not-ready state of DSR.
   assign dsr_ready = !dsp_valid;

   always_comb begin
      io_rdata = 16'h0000;
      case (addr)
         ADDR_KBSR: begin
            io_rdata[BIT_READY] = !fifo_empty;
            io_rdata[BIT_IE]    = kbsr_ie;
         end
         ADDR_KBDR: if (!fifo_empty) io_rdata = {8'h00, fifo_head};
         ADDR_DSR: begin
            io_rdata[BIT_READY] = dsr_ready;
            io_rdata[BIT_IE]    = dsr_ie;
         end
         ADDR_MCR:  io_rdata[BIT_RUN] = mcr_run;
         default:   io_rdata = 16'h0000;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         kbsr_ie   <= 1'b0;
         dsr_ie    <= 1'b0;
         mcr_run   <= 1'b1;
         dsp_valid <= 1'b0;
         dsp_data  <= 8'h00;
      end else begin
         if (io_we && addr == ADDR_KBSR) kbsr_ie <= io_wdata[BIT_IE];
         if (io_we && addr == ADDR_DSR)  dsr_ie  <= io_wdata[BIT_IE];
         if (io_we && addr == ADDR_MCR)  mcr_run <= io_wdata[BIT_RUN];
         // A DDR write coinciding with completion is dropped: dsr_ready is still 0 here.
         if (io_we && addr == ADDR_DDR && dsr_ready) begin
            dsp_valid <= 1'b1;
            dsp_data  <= io_wdata[7:0];
         end else if (dsp_valid && dsp_ready) begin
            dsp_valid <= 1'b0;
         end
      end
   end

   assign kbd_req = !fifo_empty && kbsr_ie;
   assign dsp_req = dsr_ready && dsr_ie;

   always_comb begin
      win = '0;
      if (kbd_req && (!dsp_req || KBD_PRI >= DSP_PRI)) begin
         win.pri = KBD_PRI;
         win.vec = KBD_VEC;
      end else if (dsp_req) begin
         win.pri = DSP_PRI;
         win.vec = DSP_VEC;
      end
   end

   // IRQ marks every change of the registered level, including a drop to zero.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cur <= '0;
         IRQ <= 1'b0;
      end else begin
         cur <= win;
         IRQ <= (win != cur);
      end
   end

   assign INTP = cur.pri;
   assign INTV = cur.vec;

endmodule
